sync_fifo_flex: RTL

Next-generation single-clock FIFO for datapath buffering between producer/consumer blocks in the same clock domain.
- Generalises the existing sync FIFO:
  - any depth ≥ 2, not only powers of two
  - selectable first-word-fall-through (FWFT) or registered-read mode
  - full-range occupancy count
  - programmable almost-full / almost-empty flags
  - synchronous flush
  - sticky overflow/underflow error flags

---
 rtl/sync_fifo_pkg.sv | 15 +
 rtl/sync_fifo_flex_if.sv | 29 ++
 rtl/sync_fifo_mem.sv | 44 ++++
 rtl/sync_fifo_flex.sv | 128 ++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared types and helpers for the flexible synchronous FIFO.
// Pointer increment wraps at an arbitrary depth, so non power-of-two depths work.
package sync_fifo_pkg;

  typedef struct packed {
    logic overflow;
    logic underflow;
  } err_flags_t;

  // Wrap-aware pointer increment: depth-1 rolls back to 0
  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/sync_fifo_flex_if.sv
// Producer/consumer bundle for sync_fifo_flex: write side, read side and status.
interface sync_fifo_flex_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 6
);
  logic                  flush;
  logic                  wen;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  full;
  logic                  almost_full;
  logic                  ren;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rvalid;
  logic                  empty;
  logic                  almost_empty;
  logic [CNT_WIDTH-1:0]  count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output flush, wen, wdata, ren,
    input  full, almost_full, rdata, rvalid, empty, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  flush, wen, wdata, ren,
    output full, almost_full, rdata, rvalid, empty, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_mem.sv
// FIFO storage: one write port, one read port that is either combinational
// (first-word-fall-through) or registered with a one-cycle latency.
module sync_fifo_mem #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 32,
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH),
  parameter bit          FWFT       = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  // Storage is intentionally not reset
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  if (FWFT) begin : g_fwft
    logic unused_rd;
    assign unused_rd = &{1'b0, re_i, rst_n};
    assign rdata_o   = mem_q[raddr_i];
  end else begin : g_reg
    logic [DATA_WIDTH-1:0] rdata_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rdata_q <= '0;
      end else if (re_i) begin
        rdata_q <= mem_q[raddr_i];
      end
    end
    assign rdata_o = rdata_q;
  end

endmodule

// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO with arbitrary depth, FWFT or registered read, occupancy count,
// programmable almost flags, synchronous flush and sticky error flags.
module sync_fifo_flex
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 32,
  parameter int unsigned ADDR_WIDTH = $clog2(FIFO_DEPTH),
  parameter int unsigned CNT_WIDTH  = $clog2(FIFO_DEPTH + 1),
  parameter bit          FWFT       = 1'b1,
  parameter int unsigned AF_THRESH  = FIFO_DEPTH - 2,
  parameter int unsigned AE_THRESH  = 2
) (
  input logic             clk,
  input logic             rst_n,
  sync_fifo_flex_if.slave bus
);

  if (FIFO_DEPTH < 2 || AE_THRESH >= AF_THRESH || AF_THRESH > FIFO_DEPTH ||
      CNT_WIDTH < $clog2(FIFO_DEPTH + 1) || ADDR_WIDTH < $clog2(FIFO_DEPTH)) begin : g_param_check
    $error("sync_fifo_flex: illegal parameter combination");
  end

  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  af_q, af_d;
  logic                  ae_q, ae_d;
  logic                  rvalid_q, rvalid_d;
  err_flags_t            err_q, err_d;
  logic                  rd_ok;
  logic                  wr_ok;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // Flush masks both requests; a full FIFO still accepts a write paired with a read
  assign rd_ok = bus.ren && !empty_q && !bus.flush;
  assign wr_ok = bus.wen && (!full_q || rd_ok) && !bus.flush;

  always_comb begin
    waddr_d  = waddr_q;
    raddr_d  = raddr_q;
    count_d  = count_q;
    err_d    = err_q;
    rvalid_d = rd_ok;
    if (bus.flush) begin
      waddr_d = '0;
      raddr_d = '0;
      count_d = '0;
      err_d   = '0;
    end else begin
      if (wr_ok) begin
        waddr_d = ADDR_WIDTH'(ptr_inc(32'(waddr_q), FIFO_DEPTH));
      end
      if (rd_ok) begin
        raddr_d = ADDR_WIDTH'(ptr_inc(32'(raddr_q), FIFO_DEPTH));
      end
      if (wr_ok && !rd_ok) begin
        count_d = count_q + CNT_WIDTH'(1);
      end else if (rd_ok && !wr_ok) begin
        count_d = count_q - CNT_WIDTH'(1);
      end
      if (bus.wen && !wr_ok) begin
        err_d.overflow = 1'b1;
      end
      if (bus.ren && empty_q) begin
        err_d.underflow = 1'b1;
      end
    end
    // Status flags follow the next count so they move together with it
    full_d  = (count_d == CNT_WIDTH'(FIFO_DEPTH));
    empty_d = (count_d == '0);
    af_d    = (count_d >= CNT_WIDTH'(AF_THRESH));
    ae_d    = (count_d <= CNT_WIDTH'(AE_THRESH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      waddr_q  <= '0;
      raddr_q  <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= (AF_THRESH == 0);
      ae_q     <= 1'b1;
      rvalid_q <= 1'b0;
      err_q    <= '0;
    end else begin
      waddr_q  <= waddr_d;
      raddr_q  <= raddr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      af_q     <= af_d;
      ae_q     <= ae_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
    end
  end

  sync_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .FWFT       (FWFT)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (wr_ok),
    .waddr_i (waddr_q),
    .wdata_i (bus.wdata),
    .re_i    (rd_ok),
    .raddr_i (raddr_q),
    .rdata_o (mem_rdata)
  );

  assign bus.rdata        = mem_rdata;
  assign bus.rvalid       = FWFT ? !empty_q : rvalid_q;
  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = af_q;
  assign bus.almost_empty = ae_q;
  assign bus.count        = count_q;
  assign bus.overflow     = err_q.overflow;
  assign bus.underflow    = err_q.underflow;

endmodule
